mem_stage: RTL and testbench
============================

MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have ports: clk  input  1  sole clock, rising edge.
REQ-002 SHALL have: reset  input  1  asynchronous, active-low reset.
REQ-003 SHALL have: EX_Valid  input  1  EX presents a valid instruction on EX_to_ME_Bus.
REQ-004 SHALL have: ME_Unit_Ready  output  1  stage can accept from EX this cycle.
REQ-005 SHALL have: EX_to_ME_Bus  input  74  {pc[73:42], ld_unsigned[41], ld_size[40:39], is_load[38], rf_we[37], dest[36:32], alu_result[31:0]}.
REQ-006 SHALL have: data_sram_data_ok  input  1  one-cycle pulse, load read data valid.
REQ-007 SHALL have: data_sram_rdata  input  32  load read data, valid with data_ok.
REQ-008 SHALL have: ME_Valid  output  1  ME_to_WB_Bus holds a completed instruction.
REQ-009 SHALL have: WB_Unit_Ready  input  1  WB accepts this cycle.
REQ-010 SHALL have: ME_to_WB_Bus  output  70  {pc[69:38], rf_we[37], dest[36:32], final_result[31:0]}.
REQ-011 SHALL have: ME_Busy_Dest  output  6  {pending_load, dest}: pending_load=1 while state WAIT_DATA.

Function
REQ-012 SHALL contain a 74-bit instruction register and a 32-bit load-data register; FSM states EMPTY, WAIT_DATA, HOLD.
REQ-013 SHALL compute ME_Unit_Ready = (state==EMPTY) | (state==HOLD & WB_Unit_Ready), combinationally.
REQ-014 SHALL assert ME_Valid only in state HOLD.
REQ-015 SHALL accept (capture EX_to_ME_Bus) on a rising edge where EX_Valid & ME_Unit_Ready.
REQ-016 SHALL, on accept, go to WAIT_DATA if is_load=1, else HOLD.
REQ-017 SHALL, in HOLD with WB_Unit_Ready=1 and no accept, go to EMPTY.
REQ-018 SHALL, in HOLD with WB_Unit_Ready=1 and simultaneous accept, hand off and load the new instruction in the same edge (back-to-back, no bubble).
REQ-019 SHALL, in WAIT_DATA, capture data_sram_rdata and go to HOLD on data_sram_data_ok=1; otherwise remain in WAIT_DATA indefinitely.
REQ-020 SHALL ignore data_sram_data_ok in states EMPTY and HOLD; data_ok arrives no earlier than the cycle after load acceptance.
REQ-021 SHALL hold ME_to_WB_Bus stable while ME_Valid=1 & WB_Unit_Ready=0.
REQ-022 SHALL form final_result = alu_result for non-loads.
REQ-023 SHALL, for loads, use offset = alu_result[1:0]: ld_size 00 byte rdata[8*offset+:8]; 01 half rdata[16*offset[1]+:16]; 10/11 word.
REQ-024 SHALL zero-extend byte/half if ld_unsigned=1, else sign-extend to 32 bits.
REQ-025 SHALL pass pc, rf_we and dest unchanged to ME_to_WB_Bus.
REQ-026 SHALL latency: non-load ME_Valid one cycle after accept; load ME_Valid one cycle after data_ok.

Reset
REQ-027 SHALL, while reset=0, asynchronously force state EMPTY, both registers to 0, ME_Valid=0, ME_to_WB_Bus=0, ME_Busy_Dest=0.
REQ-028 SHALL perform no accept and no data capture while reset=0.
REQ-029 SHALL, on reset assertion mid-WAIT_DATA, discard the pending load; a later data_ok is ignored.
REQ-030 SHALL resume normal operation on the first rising edge after reset deasserts.

Verification
REQ-031 Non-load: accept pc=0x1C000000, rf_we=1, dest=5, alu_result=0x12345678, WB ready -> next cycle ME_Valid=1, bus={0x1C000000,1,5,0x12345678}, then EMPTY.
REQ-032 Back-to-back: 3 non-loads with EX_Valid, WB_Unit_Ready held 1 -> ME_Valid 1 for 3 consecutive cycles, no bubble, correct order.
REQ-033 Load byte signed, offset 3, rdata=0x80FF0000, data_ok 2 cycles after accept -> ME_Busy_Dest[5]=1 for 2 cycles, final_result=0xFFFFFF80.
REQ-034 Load half unsigned, offset 2, rdata=0xBEEF1234 -> final_result=0x0000BEEF.
REQ-035 Backpressure: WB_Unit_Ready=0 for 4 cycles in HOLD -> ME_Valid=1, bus stable, ME_Unit_Ready=0; release -> single transfer.
REQ-036 Reset in WAIT_DATA, then data_ok pulse -> ME_Valid stays 0, state EMPTY, ME_Unit_Ready=1.

Source files
------------

// File: rtl/mem_stage.sv
// mem_stage: memory-access pipeline stage.
// It takes one instruction at a time from EX. Non-loads complete at once.
// Loads wait for a single data_ok pulse from the data SRAM. The read data is
// then aligned and extended, and the result is handed to WB with
// valid/ready handshaking.
//
// Ports
//   clk               : sole clock, rising edge
//   reset             : asynchronous, active-low reset
//   EX_Valid          : EX presents a valid instruction on EX_to_ME_Bus
//   ME_Unit_Ready     : stage can accept from EX this cycle (combinational)
//   EX_to_ME_Bus[73:0]: {pc, ld_unsigned, ld_size, is_load, rf_we, dest, alu_result}
//   data_sram_data_ok : one-cycle pulse, load read data valid
//   data_sram_rdata   : load read data, valid with data_ok
//   ME_Valid          : ME_to_WB_Bus holds a completed instruction
//   WB_Unit_Ready     : WB accepts this cycle
//   ME_to_WB_Bus[69:0]: {pc, rf_we, dest, final_result}
//   ME_Busy_Dest[5:0] : {pending_load, dest}
module mem_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic        EX_Valid,
    output logic        ME_Unit_Ready,
    input  logic [73:0] EX_to_ME_Bus,
    input  logic        data_sram_data_ok,
    input  logic [31:0] data_sram_rdata,
    output logic        ME_Valid,
    input  logic        WB_Unit_Ready,
    output logic [69:0] ME_to_WB_Bus,
    output logic [5:0]  ME_Busy_Dest
);

    typedef enum logic [1:0] {
        ST_EMPTY     = 2'd0,
        ST_WAIT_DATA = 2'd1,
        ST_HOLD      = 2'd2
    } state_t;

    state_t      state_r;
    state_t      state_s;
    logic [73:0] inst_r;
    logic [31:0] ldata_r;
    logic        accept_s;
    logic [31:0] final_result_s;

    // Select the addressed byte/half/word of the read data and extend it to 32 bits
    function automatic logic [31:0] load_extract(
        input logic [31:0] rdata,
        input logic [1:0]  offset,
        input logic [1:0]  size,
        input logic        is_unsigned
    );
        logic [7:0]  byte_v;
        logic [15:0] half_v;
        logic [31:0] res_v;
        case (offset)
            2'd0:    byte_v = rdata[7:0];
            2'd1:    byte_v = rdata[15:8];
            2'd2:    byte_v = rdata[23:16];
            2'd3:    byte_v = rdata[31:24];
            default: byte_v = 8'd0;
        endcase
        half_v = offset[1] ? rdata[31:16] : rdata[15:0];
        case (size)
            2'b00:   res_v = is_unsigned ? {24'd0, byte_v} : {{24{byte_v[7]}}, byte_v};
            2'b01:   res_v = is_unsigned ? {16'd0, half_v} : {{16{half_v[15]}}, half_v};
            default: res_v = rdata;
        endcase
        return res_v;
    endfunction

    // Handshake towards EX: an empty stage, or one whose result leaves this edge
    always_comb begin
        ME_Unit_Ready = 1'b0;
        if (state_r == ST_EMPTY) begin
            ME_Unit_Ready = 1'b1;
        end else if (state_r == ST_HOLD) begin
            ME_Unit_Ready = WB_Unit_Ready;
        end else begin
            ME_Unit_Ready = 1'b0;
        end
        accept_s = EX_Valid & ME_Unit_Ready;
    end

    // Next-state logic; a HOLD hand-off and a new accept may share one edge
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_EMPTY: begin
                if (accept_s) begin
                    state_s = EX_to_ME_Bus[38] ? ST_WAIT_DATA : ST_HOLD;
                end else begin
                    state_s = ST_EMPTY;
                end
            end
            ST_WAIT_DATA: begin
                if (data_sram_data_ok) begin
                    state_s = ST_HOLD;
                end else begin
                    state_s = ST_WAIT_DATA;
                end
            end
            ST_HOLD: begin
                if (accept_s) begin
                    state_s = EX_to_ME_Bus[38] ? ST_WAIT_DATA : ST_HOLD;
                end else if (WB_Unit_Ready) begin
                    state_s = ST_EMPTY;
                end else begin
                    state_s = ST_HOLD;
                end
            end
            default: state_s = ST_EMPTY;
        endcase
    end

    // State, instruction and load-data registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_EMPTY;
            inst_r  <= 74'd0;
            ldata_r <= 32'd0;
        end else begin
            state_r <= state_s;
            if (accept_s) begin
                inst_r <= EX_to_ME_Bus;
            end
            // data_ok outside WAIT_DATA is stray and must not disturb a held result
            if ((state_r == ST_WAIT_DATA) && data_sram_data_ok) begin
                ldata_r <= data_sram_rdata;
            end
        end
    end

    // Output formation from the held instruction and load data
    always_comb begin
        final_result_s = inst_r[31:0];
        if (inst_r[38]) begin
            final_result_s = load_extract(ldata_r, inst_r[1:0], inst_r[40:39], inst_r[41]);
        end else begin
            final_result_s = inst_r[31:0];
        end
        ME_Valid     = (state_r == ST_HOLD);
        ME_to_WB_Bus = {inst_r[73:42], inst_r[37], inst_r[36:32], final_result_s};
        ME_Busy_Dest = {(state_r == ST_WAIT_DATA), inst_r[36:32]};
    end

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage. Inputs change on the falling
// edge and outputs are checked on the falling edge (plus #1).
module tb_mem_stage;

    logic        clk;
    logic        reset;
    logic        EX_Valid;
    logic        ME_Unit_Ready;
    logic [73:0] EX_to_ME_Bus;
    logic        data_sram_data_ok;
    logic [31:0] data_sram_rdata;
    logic        ME_Valid;
    logic        WB_Unit_Ready;
    logic [69:0] ME_to_WB_Bus;
    logic [5:0]  ME_Busy_Dest;

    int n_vec = 0;
    int n_err = 0;

    mem_stage dut (
        .clk               (clk),
        .reset             (reset),
        .EX_Valid          (EX_Valid),
        .ME_Unit_Ready     (ME_Unit_Ready),
        .EX_to_ME_Bus      (EX_to_ME_Bus),
        .data_sram_data_ok (data_sram_data_ok),
        .data_sram_rdata   (data_sram_rdata),
        .ME_Valid          (ME_Valid),
        .WB_Unit_Ready     (WB_Unit_Ready),
        .ME_to_WB_Bus      (ME_to_WB_Bus),
        .ME_Busy_Dest      (ME_Busy_Dest)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [73:0] mk(input logic [31:0] pc, input logic uns,
                                       input logic [1:0] size, input logic ld,
                                       input logic we, input logic [4:0] dest,
                                       input logic [31:0] alu);
        return {pc, uns, size, ld, we, dest, alu};
    endfunction

    task automatic test_reset();
        reset = 1'b0;
        EX_Valid = 1'b1;
        EX_to_ME_Bus = mk(32'h1C00_0100, 1'b0, 2'b00, 1'b0, 1'b1, 5'd9, 32'hDEAD_BEEF);
        WB_Unit_Ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #1;
        n_vec++; if (ME_Valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b exp 0", ME_Valid); end
        n_vec++; if (ME_to_WB_Bus !== 70'd0) begin n_err++; $display("FAIL reset_bus got %h exp 0", ME_to_WB_Bus); end
        n_vec++; if (ME_Busy_Dest !== 6'd0) begin n_err++; $display("FAIL reset_busy got %h exp 0", ME_Busy_Dest); end
        n_vec++; if (ME_Unit_Ready !== 1'b1) begin n_err++; $display("FAIL reset_ready got %b exp 1", ME_Unit_Ready); end
        EX_Valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        #1;
        n_vec++; if (ME_Valid !== 1'b0) begin n_err++; $display("FAIL reset_release_valid got %b exp 0", ME_Valid); end
    endtask

    task automatic test_nonload();
        @(negedge clk);
        WB_Unit_Ready = 1'b1;
        EX_Valid = 1'b1;
        EX_to_ME_Bus = mk(32'h1C00_0000, 1'b0, 2'b00, 1'b0, 1'b1, 5'd5, 32'h1234_5678);
        @(negedge clk);
        EX_Valid = 1'b0;
        #1;
        n_vec++; if (ME_Valid !== 1'b1) begin n_err++; $display("FAIL nonload_valid got %b exp 1", ME_Valid); end
        n_vec++; if (ME_to_WB_Bus !== {32'h1C00_0000, 1'b1, 5'd5, 32'h1234_5678}) begin
            n_err++; $display("FAIL nonload_bus got %h exp %h", ME_to_WB_Bus, {32'h1C00_0000, 1'b1, 5'd5, 32'h1234_5678});
        end
        @(negedge clk);
        #1;
        n_vec++; if (ME_Valid !== 1'b0) begin n_err++; $display("FAIL nonload_empty got %b exp 0", ME_Valid); end
        n_vec++; if (ME_Unit_Ready !== 1'b1) begin n_err++; $display("FAIL nonload_ready got %b exp 1", ME_Unit_Ready); end
    endtask

    task automatic test_back_to_back();
        logic [73:0] v [3];
        logic [69:0] e [3];
        v[0] = mk(32'h1C00_0004, 1'b0, 2'b00, 1'b0, 1'b1, 5'd1, 32'h0000_0011);
        v[1] = mk(32'h1C00_0008, 1'b1, 2'b01, 1'b0, 1'b0, 5'd2, 32'h0000_0022);
        v[2] = mk(32'h1C00_000C, 1'b0, 2'b10, 1'b0, 1'b1, 5'd3, 32'hFFFF_FF33);
        e[0] = {32'h1C00_0004, 1'b1, 5'd1, 32'h0000_0011};
        e[1] = {32'h1C00_0008, 1'b0, 5'd2, 32'h0000_0022};
        e[2] = {32'h1C00_000C, 1'b1, 5'd3, 32'hFFFF_FF33};
        WB_Unit_Ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            if (i > 0) begin
                n_vec++; if (ME_Valid !== 1'b1) begin n_err++; $display("FAIL b2b_valid[%0d] got %b exp 1", i, ME_Valid); end
                n_vec++; if (ME_to_WB_Bus !== e[i-1]) begin n_err++; $display("FAIL b2b_bus[%0d] got %h exp %h", i, ME_to_WB_Bus, e[i-1]); end
            end
            if (i < 3) begin
                EX_Valid = 1'b1;
                EX_to_ME_Bus = v[i];
            end else begin
                EX_Valid = 1'b0;
            end
        end
        @(negedge clk);
        #1;
        n_vec++; if (ME_Valid !== 1'b0) begin n_err++; $display("FAIL b2b_drain got %b exp 0", ME_Valid); end
    endtask

    task automatic test_load_byte();
        @(negedge clk);
        WB_Unit_Ready = 1'b1;
        EX_Valid = 1'b1;
        EX_to_ME_Bus = mk(32'h1C00_0010, 1'b0, 2'b00, 1'b1, 1'b1, 5'd7, 32'h0000_1003);
        @(negedge clk);
        EX_Valid = 1'b0;
        #1;
        n_vec++; if (ME_Busy_Dest !== {1'b1, 5'd7}) begin n_err++; $display("FAIL lb_busy1 got %h exp %h", ME_Busy_Dest, {1'b1, 5'd7}); end
        n_vec++; if (ME_Valid !== 1'b0) begin n_err++; $display("FAIL lb_valid_wait got %b exp 0", ME_Valid); end
        n_vec++; if (ME_Unit_Ready !== 1'b0) begin n_err++; $display("FAIL lb_ready_wait got %b exp 0", ME_Unit_Ready); end
        @(negedge clk);
        #1;
        n_vec++; if (ME_Busy_Dest[5] !== 1'b1) begin n_err++; $display("FAIL lb_busy2 got %b exp 1", ME_Busy_Dest[5]); end
        data_sram_data_ok = 1'b1;
        data_sram_rdata = 32'h80FF_0000;
        @(negedge clk);
        data_sram_data_ok = 1'b0;
        data_sram_rdata = 32'h0000_0000;
        #1;
        n_vec++; if (ME_Valid !== 1'b1) begin n_err++; $display("FAIL lb_valid got %b exp 1", ME_Valid); end
        n_vec++; if (ME_Busy_Dest[5] !== 1'b0) begin n_err++; $display("FAIL lb_busy_clear got %b exp 0", ME_Busy_Dest[5]); end
        n_vec++; if (ME_to_WB_Bus !== {32'h1C00_0010, 1'b1, 5'd7, 32'hFFFF_FF80}) begin
            n_err++; $display("FAIL lb_bus got %h exp %h", ME_to_WB_Bus, {32'h1C00_0010, 1'b1, 5'd7, 32'hFFFF_FF80});
        end
        @(negedge clk);
        #1;
        n_vec++; if (ME_Valid !== 1'b0) begin n_err++; $display("FAIL lb_drain got %b exp 0", ME_Valid); end
    endtask

    task automatic test_load_half();
        @(negedge clk);
        WB_Unit_Ready = 1'b0;
        EX_Valid = 1'b1;
        EX_to_ME_Bus = mk(32'h1C00_0020, 1'b1, 2'b01, 1'b1, 1'b1, 5'd9, 32'h0000_2002);
        @(negedge clk);
        EX_Valid = 1'b0;
        data_sram_data_ok = 1'b1;
        data_sram_rdata = 32'hBEEF_1234;
        @(negedge clk);
        // a stray data_ok while holding must not overwrite the result
        data_sram_data_ok = 1'b1;
        data_sram_rdata = 32'h1111_2222;
        #1;
        n_vec++; if (ME_Valid !== 1'b1) begin n_err++; $display("FAIL lh_valid got %b exp 1", ME_Valid); end
        n_vec++; if (ME_to_WB_Bus !== {32'h1C00_0020, 1'b1, 5'd9, 32'h0000_BEEF}) begin
            n_err++; $display("FAIL lh_bus got %h exp %h", ME_to_WB_Bus, {32'h1C00_0020, 1'b1, 5'd9, 32'h0000_BEEF});
        end
        @(negedge clk);
        data_sram_data_ok = 1'b0;
        #1;
        n_vec++; if (ME_to_WB_Bus[31:0] !== 32'h0000_BEEF) begin n_err++; $display("FAIL lh_stray_ok got %h exp 0000beef", ME_to_WB_Bus[31:0]); end
        WB_Unit_Ready = 1'b1;
        @(negedge clk);
        #1;
        n_vec++; if (ME_Valid !== 1'b0) begin n_err++; $display("FAIL lh_drain got %b exp 0", ME_Valid); end
    endtask

    task automatic test_backpressure();
        int xfers;
        @(negedge clk);
        WB_Unit_Ready = 1'b0;
        EX_Valid = 1'b1;
        EX_to_ME_Bus = mk(32'h1C00_0030, 1'b0, 2'b00, 1'b0, 1'b1, 5'd3, 32'hCAFE_F00D);
        @(negedge clk);
        EX_Valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1;
            n_vec++; if (ME_Valid !== 1'b1) begin n_err++; $display("FAIL bp_valid[%0d] got %b exp 1", k, ME_Valid); end
            n_vec++; if (ME_to_WB_Bus !== {32'h1C00_0030, 1'b1, 5'd3, 32'hCAFE_F00D}) begin
                n_err++; $display("FAIL bp_bus[%0d] got %h exp %h", k, ME_to_WB_Bus, {32'h1C00_0030, 1'b1, 5'd3, 32'hCAFE_F00D});
            end
            n_vec++; if (ME_Unit_Ready !== 1'b0) begin n_err++; $display("FAIL bp_ready[%0d] got %b exp 0", k, ME_Unit_Ready); end
            @(negedge clk);
        end
        WB_Unit_Ready = 1'b1;
        #1;
        n_vec++; if (ME_Unit_Ready !== 1'b1) begin n_err++; $display("FAIL bp_release_ready got %b exp 1", ME_Unit_Ready); end
        xfers = 0;
        for (int k = 0; k < 3; k++) begin
            if (ME_Valid && WB_Unit_Ready) xfers++;
            @(negedge clk);
            #1;
        end
        n_vec++; if (xfers != 1) begin n_err++; $display("FAIL bp_transfers got %0d exp 1", xfers); end
    endtask

    task automatic test_reset_wait();
        @(negedge clk);
        WB_Unit_Ready = 1'b1;
        EX_Valid = 1'b1;
        EX_to_ME_Bus = mk(32'h1C00_0040, 1'b0, 2'b10, 1'b1, 1'b1, 5'd4, 32'h0000_0000);
        @(negedge clk);
        EX_Valid = 1'b0;
        #1;
        n_vec++; if (ME_Busy_Dest !== {1'b1, 5'd4}) begin n_err++; $display("FAIL rw_busy_pre got %h exp %h", ME_Busy_Dest, {1'b1, 5'd4}); end
        reset = 1'b0;
        #1;
        n_vec++; if (ME_Busy_Dest !== 6'd0) begin n_err++; $display("FAIL rw_busy_async got %h exp 0", ME_Busy_Dest); end
        n_vec++; if (ME_to_WB_Bus !== 70'd0) begin n_err++; $display("FAIL rw_bus_async got %h exp 0", ME_to_WB_Bus); end
        @(negedge clk);
        reset = 1'b1;
        data_sram_data_ok = 1'b1;
        data_sram_rdata = 32'h5555_AAAA;
        @(negedge clk);
        data_sram_data_ok = 1'b0;
        #1;
        n_vec++; if (ME_Valid !== 1'b0) begin n_err++; $display("FAIL rw_valid got %b exp 0", ME_Valid); end
        n_vec++; if (ME_Unit_Ready !== 1'b1) begin n_err++; $display("FAIL rw_ready got %b exp 1", ME_Unit_Ready); end
        n_vec++; if (ME_Busy_Dest !== 6'd0) begin n_err++; $display("FAIL rw_busy got %h exp 0", ME_Busy_Dest); end
        // normal operation resumes
        EX_Valid = 1'b1;
        EX_to_ME_Bus = mk(32'h1C00_0044, 1'b0, 2'b00, 1'b0, 1'b0, 5'd6, 32'h0BAD_F00D);
        @(negedge clk);
        EX_Valid = 1'b0;
        #1;
        n_vec++; if (ME_to_WB_Bus !== {32'h1C00_0044, 1'b0, 5'd6, 32'h0BAD_F00D} || ME_Valid !== 1'b1) begin
            n_err++; $display("FAIL rw_resume got %b/%h exp 1/%h", ME_Valid, ME_to_WB_Bus, {32'h1C00_0044, 1'b0, 5'd6, 32'h0BAD_F00D});
        end
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b0;
        EX_Valid = 1'b0;
        EX_to_ME_Bus = 74'd0;
        data_sram_data_ok = 1'b0;
        data_sram_rdata = 32'd0;
        WB_Unit_Ready = 1'b0;
        test_reset();
        test_nonload();
        test_back_to_back();
        test_load_byte();
        test_load_half();
        test_backpressure();
        test_reset_wait();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
